// File: rtl/cache_pagefault_check_pkg.sv
// Shared cache command, privilege, PTE flag and page-fault cause definitions,
// plus the single fault evaluation function used by cache_pagefault_check.
package cache_pagefault_check_pkg;

    typedef enum logic [3:0] {
        CACHE_CMD_NONE       = 4'd0,
        CACHE_CMD_EXECUTE    = 4'd1,
        CACHE_CMD_LOAD       = 4'd2,
        CACHE_CMD_STORE      = 4'd3,
        CACHE_CMD_FLUSH      = 4'd4,
        CACHE_CMD_INVALIDATE = 4'd5
    } cache_cmd_e;

    typedef enum logic [1:0] {
        COREVX_PRIVILEGE_USER       = 2'd0,
        COREVX_PRIVILEGE_SUPERVISOR = 2'd1,
        COREVX_PRIVILEGE_MACHINE    = 2'd3
    } corevx_privilege_e;

    localparam int unsigned TAG_V = 0;
    localparam int unsigned TAG_R = 1;
    localparam int unsigned TAG_W = 2;
    localparam int unsigned TAG_X = 3;
    localparam int unsigned TAG_U = 4;
    localparam int unsigned TAG_G = 5;
    localparam int unsigned TAG_A = 6;
    localparam int unsigned TAG_D = 7;

    typedef enum logic [3:0] {
        PF_CAUSE_NONE      = 4'd0,
        PF_CAUSE_INVALID   = 4'd1,
        PF_CAUSE_RSVD_RWX  = 4'd2,
        PF_CAUSE_S_ON_U    = 4'd3,
        PF_CAUSE_U_ON_S    = 4'd4,
        PF_CAUSE_NOT_ACC   = 4'd5,
        PF_CAUSE_NO_X      = 4'd6,
        PF_CAUSE_NO_R      = 4'd7,
        PF_CAUSE_NO_W      = 4'd8,
        PF_CAUSE_NOT_DIRTY = 4'd9
    } pf_cause_e;

    // Returns the highest-priority failing check; PF_CAUSE_NONE means no fault.
    function automatic pf_cause_e pagefault_eval(
        input logic       satp_mode,
        input logic       mprv,
        input logic       mxr,
        input logic       sum,
        input logic [1:0] mpp,
        input logic [1:0] cur_priv,
        input logic [3:0] cmd,
        input logic [7:0] tag
    );
        logic       is_x;
        logic       is_l;
        logic       is_s;
        logic [1:0] eff_priv;
        pf_cause_e  cause;

        is_x     = (cmd == CACHE_CMD_EXECUTE);
        is_l     = (cmd == CACHE_CMD_LOAD);
        is_s     = (cmd == CACHE_CMD_STORE);
        eff_priv = (mprv && (is_l || is_s)) ? mpp : cur_priv;
        cause    = PF_CAUSE_NONE;

        if (!satp_mode || (eff_priv == COREVX_PRIVILEGE_MACHINE) || !(is_x || is_l || is_s)) begin
            cause = PF_CAUSE_NONE;
        end else if (!tag[TAG_V]) begin
            cause = PF_CAUSE_INVALID;
        end else if ((tag[TAG_W] && !tag[TAG_R]) ||
                     (!tag[TAG_R] && !tag[TAG_W] && !tag[TAG_X])) begin
            cause = PF_CAUSE_RSVD_RWX;
        end else if (tag[TAG_U] && (eff_priv == COREVX_PRIVILEGE_SUPERVISOR) && !sum) begin
            cause = PF_CAUSE_S_ON_U;
        end else if (!tag[TAG_U] && (eff_priv == COREVX_PRIVILEGE_USER)) begin
            cause = PF_CAUSE_U_ON_S;
        end else if (!tag[TAG_A]) begin
            cause = PF_CAUSE_NOT_ACC;
        end else if (is_x && !tag[TAG_X]) begin
            cause = PF_CAUSE_NO_X;
        end else if (is_l && !tag[TAG_R] && !(mxr && tag[TAG_X])) begin
            cause = PF_CAUSE_NO_R;
        end else if (is_s && !tag[TAG_W]) begin
            cause = PF_CAUSE_NO_W;
        end else if (is_s && !tag[TAG_D]) begin
            cause = PF_CAUSE_NOT_DIRTY;
        end
        return cause;
    endfunction

endpackage

// File: rtl/cache_pagefault_check_if.sv
// Page-fault check bus; pagefault_cause exists only with COREVX_PAGEFAULT_CAUSE_EN.
interface cache_pagefault_check_if;

    logic       csr_satp_mode_r;
    logic       os_csr_mstatus_mprv;
    logic       os_csr_mstatus_mxr;
    logic       os_csr_mstatus_sum;
    logic [1:0] os_csr_mstatus_mpp;
    logic [1:0] os_csr_mcurrent_privilege;
    logic [3:0] os_cmd;
    logic [7:0] tlb_read_accesstag;
    logic       pagefault;
    logic       pagefault_q;

`ifdef COREVX_PAGEFAULT_CAUSE_EN
    logic [3:0] pagefault_cause;

    modport master (
        output csr_satp_mode_r, os_csr_mstatus_mprv, os_csr_mstatus_mxr, os_csr_mstatus_sum,
               os_csr_mstatus_mpp, os_csr_mcurrent_privilege, os_cmd, tlb_read_accesstag,
        input  pagefault, pagefault_q, pagefault_cause
    );

    modport slave (
        input  csr_satp_mode_r, os_csr_mstatus_mprv, os_csr_mstatus_mxr, os_csr_mstatus_sum,
               os_csr_mstatus_mpp, os_csr_mcurrent_privilege, os_cmd, tlb_read_accesstag,
        output pagefault, pagefault_q, pagefault_cause
    );
`else
    modport master (
        output csr_satp_mode_r, os_csr_mstatus_mprv, os_csr_mstatus_mxr, os_csr_mstatus_sum,
               os_csr_mstatus_mpp, os_csr_mcurrent_privilege, os_cmd, tlb_read_accesstag,
        input  pagefault, pagefault_q
    );

    modport slave (
        input  csr_satp_mode_r, os_csr_mstatus_mprv, os_csr_mstatus_mxr, os_csr_mstatus_sum,
               os_csr_mstatus_mpp, os_csr_mcurrent_privilege, os_cmd, tlb_read_accesstag,
        output pagefault, pagefault_q
    );
`endif

endinterface

// File: rtl/cache_pagefault_check.sv
// Sv32 page-fault check: combinational pagefault plus registered copy.
// Optional registered pagefault_cause when COREVX_PAGEFAULT_CAUSE_EN is defined.
module cache_pagefault_check
    import cache_pagefault_check_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    cache_pagefault_check_if.slave bus
);

    pf_cause_e cause_d;
    logic      pagefault_d;
    logic      pagefault_q;

    // Fault flag is derived from the cause so the two can never disagree.
    always_comb begin
        cause_d     = pagefault_eval(bus.csr_satp_mode_r,
                                     bus.os_csr_mstatus_mprv,
                                     bus.os_csr_mstatus_mxr,
                                     bus.os_csr_mstatus_sum,
                                     bus.os_csr_mstatus_mpp,
                                     bus.os_csr_mcurrent_privilege,
                                     bus.os_cmd,
                                     bus.tlb_read_accesstag);
        pagefault_d = (cause_d != PF_CAUSE_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pagefault_q <= 1'b0;
        end else begin
            pagefault_q <= pagefault_d;
        end
    end

    assign bus.pagefault   = pagefault_d;
    assign bus.pagefault_q = pagefault_q;

`ifdef COREVX_PAGEFAULT_CAUSE_EN
    pf_cause_e cause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q <= PF_CAUSE_NONE;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign bus.pagefault_cause = cause_q;
`endif

endmodule

// File: tb/tb_cache_pagefault_check.sv
// Directed-vector bench for cache_pagefault_check; checks pagefault_cause when
// COREVX_PAGEFAULT_CAUSE_EN is defined.
module tb_cache_pagefault_check;
    import cache_pagefault_check_pkg::*;

    localparam logic [1:0] PU = 2'd0;
    localparam logic [1:0] PS = 2'd1;
    localparam logic [1:0] PM = 2'd3;
    localparam logic [3:0] CX = 4'd1;
    localparam logic [3:0] CL = 4'd2;
    localparam logic [3:0] CS = 4'd3;

    typedef struct {
        logic       satp;
        logic       mprv;
        logic       mxr;
        logic       sum;
        logic [1:0] mpp;
        logic [1:0] priv;
        logic [3:0] cmd;
        logic [7:0] tag;
        logic       exp_pf;
        logic [3:0] exp_cause;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;
    vec_t vecs[$];

    cache_pagefault_check_if bus ();

    cache_pagefault_check dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic satp, input logic mprv, input logic mxr, input logic sum,
                       input logic [1:0] mpp, input logic [1:0] priv, input logic [3:0] cmd,
                       input logic [7:0] tag, input logic exp_pf, input logic [3:0] exp_cause);
        vec_t v;
        v.satp = satp; v.mprv = mprv; v.mxr = mxr; v.sum = sum;
        v.mpp = mpp; v.priv = priv; v.cmd = cmd; v.tag = tag;
        v.exp_pf = exp_pf; v.exp_cause = exp_cause;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.csr_satp_mode_r           = v.satp;
        bus.os_csr_mstatus_mprv       = v.mprv;
        bus.os_csr_mstatus_mxr        = v.mxr;
        bus.os_csr_mstatus_sum        = v.sum;
        bus.os_csr_mstatus_mpp        = v.mpp;
        bus.os_csr_mcurrent_privilege = v.priv;
        bus.os_cmd                    = v.cmd;
        bus.tlb_read_accesstag        = v.tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [7:0] sweep_tags [5];
        sweep_tags[0] = 8'h00; sweep_tags[1] = 8'hDE; sweep_tags[2] = 8'h0F;
        sweep_tags[3] = 8'h9F; sweep_tags[4] = 8'hFF;

        //   satp mprv mxr sum mpp priv cmd tag    pf cause
        add(1, 0, 0, 0, PU, PS, CL, 8'hDF, 1, 4'd3);
        add(1, 0, 0, 1, PU, PS, CX, 8'hDF, 0, 4'd0);
        add(1, 0, 0, 1, PU, PS, CL, 8'hDF, 0, 4'd0);
        add(1, 0, 0, 1, PU, PS, CS, 8'hDF, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CX, 8'hD7, 1, 4'd6);
        add(1, 0, 0, 0, PU, PU, CX, 8'hD9, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CS, 8'hDB, 1, 4'd8);
        add(1, 0, 0, 0, PU, PU, CS, 8'hD7, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CL, 8'hD9, 1, 4'd7);
        add(1, 0, 0, 0, PU, PU, CL, 8'hD3, 0, 4'd0);
        add(1, 0, 1, 0, PU, PU, CL, 8'hD9, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CL, 8'h5F, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CX, 8'h5F, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CS, 8'h5F, 1, 4'd9);
        add(1, 0, 0, 0, PU, PU, CL, 8'h9F, 1, 4'd5);
        add(1, 0, 0, 0, PU, PU, CX, 8'h9F, 1, 4'd5);
        add(1, 0, 0, 0, PU, PU, CS, 8'h9F, 1, 4'd5);
        add(1, 0, 0, 0, PU, PU, CL, 8'hDE, 1, 4'd1);
        add(1, 0, 0, 0, PU, PU, CX, 8'hDE, 1, 4'd1);
        add(1, 0, 0, 0, PU, PU, CS, 8'hDE, 1, 4'd1);
        add(1, 1, 0, 0, PU, PM, CL, 8'h0F, 1, 4'd4);
        add(1, 1, 0, 0, PU, PM, CX, 8'h0F, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CL, 8'hDD, 1, 4'd2);
        add(1, 0, 0, 0, PU, PU, CL, 8'hD1, 1, 4'd2);
        add(1, 0, 0, 0, PU, PS, CL, 8'hCF, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, CL, 8'hCF, 1, 4'd4);
        add(1, 0, 0, 0, PU, PU, CL, 8'hF3, 0, 4'd0);
        add(1, 1, 0, 0, PM, PU, CX, 8'hCF, 1, 4'd4);
        add(1, 1, 0, 0, PM, PU, CL, 8'hCF, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, 4'd0, 8'hDE, 0, 4'd0);
        add(1, 0, 0, 0, PU, PU, 4'd4, 8'hDE, 0, 4'd0);

        // Reset: registered outputs held low while the combinational path still faults.
        v = vecs[17];
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pf_comb", {7'd0, bus.pagefault}, 8'd1);
        chk("rst_pf_q", {7'd0, bus.pagefault_q}, 8'd0);
`ifdef COREVX_PAGEFAULT_CAUSE_EN
        chk("rst_cause", {4'd0, bus.pagefault_cause}, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge_pf_q", {7'd0, bus.pagefault_q}, 8'd1);
`ifdef COREVX_PAGEFAULT_CAUSE_EN
        chk("first_edge_cause", {4'd0, bus.pagefault_cause}, 8'd1);
`endif

        // Asynchronous reset mid-cycle clears pagefault_q without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pf_q", {7'd0, bus.pagefault_q}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("pf[%0d]", i), {7'd0, bus.pagefault}, {7'd0, vecs[i].exp_pf});
            @(posedge clk);
            #1;
            chk($sformatf("pf_q[%0d]", i), {7'd0, bus.pagefault_q}, {7'd0, vecs[i].exp_pf});
`ifdef COREVX_PAGEFAULT_CAUSE_EN
            chk($sformatf("cause[%0d]", i), {4'd0, bus.pagefault_cause}, {4'd0, vecs[i].exp_cause});
`endif
        end

        // Bare mode and machine privilege never fault, whatever the tag/command.
        for (int c = 0; c < 8; c++) begin
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                v.satp = 1'b0; v.mprv = 1'b0; v.mxr = 1'b0; v.sum = 1'b0;
                v.mpp = PU; v.priv = PU; v.cmd = 4'(c); v.tag = sweep_tags[t];
                drive(v);
                #1;
                chk($sformatf("bare c%0d t%0d", c, t), {7'd0, bus.pagefault}, 8'd0);
                v.satp = 1'b1; v.priv = PM;
                drive(v);
                #1;
                chk($sformatf("mach c%0d t%0d", c, t), {7'd0, bus.pagefault}, 8'd0);
            end
        end

        // pagefault_q lags by exactly one edge on a 0->1->0 sequence.
        @(negedge clk);
        drive(vecs[20]);
        #1;
        chk("lag_pf_now", {7'd0, bus.pagefault}, 8'd1);
        chk("lag_pf_q_old", {7'd0, bus.pagefault_q}, 8'd0);
        @(posedge clk);
        #1;
        chk("lag_pf_q_new", {7'd0, bus.pagefault_q}, 8'd1);
        @(negedge clk);
        drive(vecs[21]);
        #1;
        chk("lag_pf_q_hold", {7'd0, bus.pagefault_q}, 8'd1);
        @(posedge clk);
        #1;
        chk("lag_pf_q_clear", {7'd0, bus.pagefault_q}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_pagefault_check.md
CACHE_PAGEFAULT_CHECK -- requirements
Module: corevx_cache_pagefault

Interface
REQ-001 SHALL have ports clk, rst, csr_satp_mode_r, os_csr_mstatus_mprv, os_csr_mstatus_mxr, os_csr_mstatus_sum, os_csr_mstatus_mpp, os_csr_mcurrent_privilege, os_cmd, tlb_read_accesstag, pagefault, pagefault_q, and (REQ-019) pagefault_cause.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, as follows:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- csr_satp_mode_r  in  1  0 = bare (no translation), 1 = Sv32 paging
- os_csr_mstatus_mprv  in  1  loads/stores use MPP privilege
- os_csr_mstatus_mxr  in  1  loads allowed from execute-only pages
- os_csr_mstatus_sum  in  1  supervisor may access U pages
- os_csr_mstatus_mpp  in  2  previous privilege
- os_csr_mcurrent_privilege  in  2  current privilege (USER=0, SUPERVISOR=1, MACHINE=3)
- os_cmd  in  4  cache command (CACHE_CMD_NONE/EXECUTE/LOAD/STORE/others)
- tlb_read_accesstag  in  8  PTE flags: [0]V [1]R [2]W [3]X [4]U [5]G [6]A [7]D
- pagefault  out  1  combinational fault for the current inputs
- pagefault_q  out  1  pagefault registered by clk

Function
REQ-003 pagefault SHALL be purely combinational: zero-cycle latency from any input.
REQ-004 Effective privilege SHALL equal os_csr_mstatus_mpp when mprv=1 and os_cmd is LOAD or STORE; otherwise it SHALL equal os_csr_mcurrent_privilege.
REQ-005 pagefault SHALL be 0 when csr_satp_mode_r=0, when effective privilege is MACHINE, or when os_cmd is not EXECUTE, LOAD or STORE.
REQ-006 Otherwise pagefault SHALL be 1 if any of the following holds:
- V=0
- W=1 with R=0 (reserved combination)
- R=W=X=0 (non-leaf)
- A=0
- U=1, effective privilege SUPERVISOR, sum=0
- U=0, effective privilege USER
- EXECUTE with X=0
- LOAD with R=0, unless mxr=1 and X=1
- STORE with W=0
- STORE with D=0
REQ-007 With sum=1, a SUPERVISOR access to a U=1 page SHALL not fault on the U bit, for all three commands including EXECUTE.
REQ-008 D=0 SHALL not fault LOAD or EXECUTE. The G bit SHALL be ignored.
REQ-009 pagefault_q SHALL capture pagefault on every rising clk edge.

Reset
REQ-010 While rst=1, pagefault_q SHALL be 0 asynchronously, and pagefault_cause (when present) SHALL be 0.
REQ-011 pagefault SHALL remain combinational during reset, unaffected by rst.
REQ-012 The first rising edge after rst deasserts SHALL load the current evaluation into the registers.

Configuration
REQ-013 Macro COREVX_PAGEFAULT_CAUSE_EN present: the block SHALL add output pagefault_cause[3:0], registered on clk.
REQ-014 pagefault_cause SHALL hold the highest-priority failing check from the previous cycle. Codes, in priority order:
- 1 V=0
- 2 reserved RWX
- 3 S-mode access to U page
- 4 U-mode access to S page
- 5 A=0
- 6 X missing
- 7 R missing
- 8 W missing
- 9 D=0
- 0 no fault
REQ-015 Macro absent: the block SHALL have no pagefault_cause port and no cause logic; pagefault and pagefault_q SHALL behave identically in both builds.

Structure
REQ-016 CACHE_CMD_* codes, COREVX_PRIVILEGE_* codes, accesstag bit indices and cause codes SHALL come from the shared package/header used by the cache.
REQ-017 The design SHALL be a single module with no sub-modules.
REQ-018 The fault/cause evaluation SHALL be one combinational function so that pagefault and pagefault_cause cannot diverge.
REQ-019 pagefault_cause SHALL exist only when COREVX_PAGEFAULT_CAUSE_EN is defined.

Verification
REQ-020 satp=0 or MACHINE privilege, any tag/cmd -> pagefault=0. Also rst=1 -> pagefault_q=0.
REQ-021 SUPERVISOR, sum=0, tag 8'hDF, LOAD -> pagefault=1 (cause 3). The same case with sum=1 and EXECUTE -> pagefault=0.
REQ-022 USER cases:
- EXECUTE, tag 8'hD7 -> 1; tag 8'hD9 -> 0
- STORE, tag 8'hDB -> 1; tag 8'hD7 -> 0
- LOAD, tag 8'hD9 -> 1; tag 8'hD3 -> 0
REQ-023 USER, LOAD, tag 8'hD9: mxr=1 -> 0; mxr=0 -> 1.
REQ-024 USER, tag 8'h5F: LOAD/EXECUTE -> 0, STORE -> 1. Tag 8'h9F, any cmd -> 1. Tag 8'hDE, any cmd -> 1.
REQ-025 MACHINE, mprv=1, mpp=USER, LOAD, tag 8'h0F -> 1; same with EXECUTE -> 0. pagefault_q SHALL follow one cycle later.
